// File: rtl/wb_result_capture_pkg.sv
// Shared types and constants for the writeback result capture path.
package wb_capture_pkg;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;
endpackage

// File: rtl/wb_result_capture_if.sv
// Bus bundle between the writeback snooper and its user (CPU side in, display side out).
interface wb_result_capture_if #(
    parameter int DEPTH = 4
);
    import wb_capture_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              RegWriteW;
    logic [4:0]        RdW;
    logic [DATA_W-1:0] ResultW;
    logic [4:0]        watch_reg;
    logic              clr_ovf;
    logic [DATA_W-1:0] display_value;
    logic              new_value;
    logic              shown_valid;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport slave (
        input  RegWriteW, RdW, ResultW, watch_reg, clr_ovf,
        output display_value, new_value, shown_valid, fifo_count, overflow
    );

    modport master (
        output RegWriteW, RdW, ResultW, watch_reg, clr_ovf,
        input  display_value, new_value, shown_valid, fifo_count, overflow
    );
endinterface

// File: rtl/wb_result_capture_result_fifo.sv
// Small power-of-two FIFO holding captured writeback values; a push into a
// full FIFO is still accepted when the head is popped on the same edge.
module result_fifo
    import wb_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [DATA_W-1:0]      i_data,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [PW:0]       r_count;
    logic              w_pushOk;
    logic              w_popOk;

    assign o_full   = (r_count == (PW + 1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_popOk  = i_pop && !o_empty;
    assign w_pushOk = i_push && (!o_full || w_popOk);
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // When full, write and read pointers coincide; the head is read before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_result_capture.sv
// Captures writebacks to one watched register and replays them on a stable
// output, each held for HOLD_CYCLES so the seven-segment display stays readable.
module wb_result_capture
    import wb_capture_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    wb_result_capture_if.slave bus
);
    localparam int                 DWELL_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] HOLD_LOAD = DWELL_W'(HOLD_CYCLES - 1);

    state_t                  r_state;
    logic [DWELL_W-1:0]      r_dwell;
    logic [DATA_W-1:0]       r_display;
    logic                    r_newValue;
    logic                    r_shownValid;
    logic                    r_overflow;

    logic                    w_capture;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic [DATA_W-1:0]       w_head;
    logic [$clog2(DEPTH):0]  w_count;

    // Register x0 is hardwired zero, so writes to it are never interesting.
    assign w_capture = bus.RegWriteW && (bus.RdW == bus.watch_reg) && (bus.RdW != 5'd0);
    assign w_pop     = !w_empty && ((r_state == IDLE) || (r_dwell == '0));
    assign w_drop    = w_capture && w_full && !w_pop;

    result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_capture),
        .i_pop  (w_pop),
        .i_data (bus.ResultW),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_dwell      <= '0;
            r_display    <= '0;
            r_newValue   <= 1'b0;
            r_shownValid <= 1'b0;
        end else begin
            r_newValue <= 1'b0;
            if (w_pop) begin
                r_display    <= w_head;
                r_newValue   <= 1'b1;
                r_shownValid <= 1'b1;
                r_dwell      <= HOLD_LOAD;
                r_state      <= SHOW;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    SHOW: begin
                        if (r_dwell != '0) begin
                            r_dwell <= r_dwell - 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // A drop in the same cycle as a clear must still leave the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.display_value = r_display;
    assign bus.new_value     = r_newValue;
    assign bus.shown_valid   = r_shownValid;
    assign bus.fifo_count    = w_count;
    assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_wb_result_capture.sv
// Directed bench for wb_result_capture with DEPTH=4 and HOLD_CYCLES=4.
module tb_wb_result_capture;
    import wb_capture_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_result_capture_if #(.DEPTH(4)) bus ();

    wb_result_capture #(
        .DEPTH      (4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs reflect that edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setCapture(input logic en, input logic [4:0] rd, input logic [31:0] val);
        bus.RegWriteW = en;
        bus.RdW       = rd;
        bus.ResultW   = val;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.watch_reg = 5'd5;
        bus.clr_ovf   = 1'b0;
        setCapture(1'b0, 5'd0, 32'h0);
        stepCycle();
        stepCycle();
        checks++;
        if (bus.display_value !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_display: got %h expected %h", bus.display_value, 32'h0);
        end
        checks++;
        if (bus.new_value !== 1'b0 || bus.shown_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got new=%b shown=%b expected 0 0", bus.new_value, bus.shown_valid);
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_count_ovf: got count=%0d ovf=%b expected 0 0", bus.fifo_count, bus.overflow);
        end
        rst = 1'b1;
        stepCycle();
    endtask

    task automatic test_single();
        setCapture(1'b1, 5'd5, 32'h0000_00AB);
        stepCycle();
        setCapture(1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.fifo_count !== 3'd1 || bus.new_value !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_stored: got count=%0d new=%b expected 1 0", bus.fifo_count, bus.new_value);
        end
        stepCycle();
        checks++;
        if (bus.display_value !== 32'hAB || bus.new_value !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_load: got %h new=%b expected %h new=1", bus.display_value, bus.new_value, 32'hAB);
        end
        checks++;
        if (bus.shown_valid !== 1'b1 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL single_valid: got shown=%b count=%0d expected 1 0", bus.shown_valid, bus.fifo_count);
        end
        for (int k = 2; k <= 5; k++) begin
            stepCycle();
            checks++;
            if (bus.new_value !== 1'b0) begin
                failures++;
                $display("[TB] FAIL single_quiet k=%0d: got new=%b expected 0", k, bus.new_value);
            end
            if (k == 4) begin
                checks++;
                if (dut.r_state !== SHOW) begin
                    failures++;
                    $display("[TB] FAIL single_still_show: got %0d expected %0d", dut.r_state, SHOW);
                end
            end
        end
        checks++;
        if (dut.r_state !== IDLE || bus.display_value !== 32'hAB) begin
            failures++;
            $display("[TB] FAIL single_idle: got state=%0d val=%h expected %0d %h", dut.r_state, bus.display_value, IDLE, 32'hAB);
        end
    endtask

    task automatic test_filter();
        setCapture(1'b1, 5'd6, 32'h0000_0066);
        stepCycle();
        checks++;
        if (bus.fifo_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL filter_rd6: got count=%0d expected 0", bus.fifo_count);
        end
        setCapture(1'b0, 5'd5, 32'h0000_0055);
        stepCycle();
        checks++;
        if (bus.fifo_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL filter_nowrite: got count=%0d expected 0", bus.fifo_count);
        end
        bus.watch_reg = 5'd0;
        setCapture(1'b1, 5'd0, 32'h0000_0077);
        stepCycle();
        checks++;
        if (bus.fifo_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL filter_x0: got count=%0d expected 0", bus.fifo_count);
        end
        setCapture(1'b0, 5'd0, 32'h0);
        bus.watch_reg = 5'd5;
        stepCycle();
        checks++;
        if (bus.new_value !== 1'b0 || bus.display_value !== 32'hAB) begin
            failures++;
            $display("[TB] FAIL filter_display: got %h new=%b expected %h new=0", bus.display_value, bus.new_value, 32'hAB);
        end
    endtask

    task automatic test_burst();
        logic [2:0]  peak;
        logic [31:0] expVal;
        logic        expNew;
        int          expCount [4] = '{1, 1, 2, 3};
        peak = 3'd0;
        for (int k = 0; k < 4; k++) begin
            setCapture(1'b1, 5'd5, 32'(k + 1));
            stepCycle();
            if (bus.fifo_count > peak) peak = bus.fifo_count;
            checks++;
            if (bus.fifo_count !== 3'(expCount[k])) begin
                failures++;
                $display("[TB] FAIL burst_count k=%0d: got %0d expected %0d", k, bus.fifo_count, expCount[k]);
            end
            if (k == 1) begin
                checks++;
                if (bus.new_value !== 1'b1 || bus.display_value !== 32'h1) begin
                    failures++;
                    $display("[TB] FAIL burst_first: got %h new=%b expected 1 new=1", bus.display_value, bus.new_value);
                end
            end
        end
        setCapture(1'b0, 5'd0, 32'h0);
        for (int k = 4; k <= 17; k++) begin
            stepCycle();
            if (bus.fifo_count > peak) peak = bus.fifo_count;
            expNew = (k == 5) || (k == 9) || (k == 13);
            checks++;
            if (bus.new_value !== expNew) begin
                failures++;
                $display("[TB] FAIL burst_pulse k=%0d: got %b expected %b", k, bus.new_value, expNew);
            end
            if (expNew) begin
                expVal = (k == 5) ? 32'h2 : ((k == 9) ? 32'h3 : 32'h4);
                checks++;
                if (bus.display_value !== expVal) begin
                    failures++;
                    $display("[TB] FAIL burst_value k=%0d: got %h expected %h", k, bus.display_value, expVal);
                end
            end
        end
        checks++;
        if (peak !== 3'd3) begin
            failures++;
            $display("[TB] FAIL burst_peak: got %0d expected 3", peak);
        end
    endtask

    // 0x15 lands on a pop edge with the FIFO full and is kept; 0x16 is the one dropped.
    task automatic test_overflow();
        int          expCount [7] = '{1, 1, 2, 3, 4, 4, 4};
        logic [31:0] expVal;
        logic        expNew;
        for (int k = 0; k < 7; k++) begin
            setCapture(1'b1, 5'd5, 32'h10 + 32'(k));
            stepCycle();
            checks++;
            if (bus.fifo_count !== 3'(expCount[k]) || bus.overflow !== (k == 6)) begin
                failures++;
                $display("[TB] FAIL ovf_fill k=%0d: got count=%0d ovf=%b expected %0d %b", k, bus.fifo_count, bus.overflow, expCount[k], (k == 6));
            end
            if (k == 1 || k == 5) begin
                expVal = (k == 1) ? 32'h10 : 32'h11;
                checks++;
                if (bus.new_value !== 1'b1 || bus.display_value !== expVal) begin
                    failures++;
                    $display("[TB] FAIL ovf_load k=%0d: got %h new=%b expected %h new=1", k, bus.display_value, bus.new_value, expVal);
                end
            end
        end
        setCapture(1'b0, 5'd0, 32'h0);
        bus.clr_ovf = 1'b1;
        stepCycle();
        checks++;
        if (bus.overflow !== 1'b0 || bus.fifo_count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL ovf_clear: got ovf=%b count=%0d expected 0 4", bus.overflow, bus.fifo_count);
        end
        setCapture(1'b1, 5'd5, 32'h20);
        stepCycle();
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL ovf_set_wins: got ovf=%b count=%0d expected 1 4", bus.overflow, bus.fifo_count);
        end
        setCapture(1'b0, 5'd0, 32'h0);
        bus.clr_ovf = 1'b0;
        for (int k = 9; k <= 25; k++) begin
            stepCycle();
            expNew = ((k - 9) % 4) == 0 && k <= 21;
            checks++;
            if (bus.new_value !== expNew) begin
                failures++;
                $display("[TB] FAIL ovf_drain_pulse k=%0d: got %b expected %b", k, bus.new_value, expNew);
            end
            if (expNew) begin
                expVal = 32'h12 + 32'((k - 9) / 4);
                checks++;
                if (bus.display_value !== expVal) begin
                    failures++;
                    $display("[TB] FAIL ovf_drain_value k=%0d: got %h expected %h", k, bus.display_value, expVal);
                end
            end
        end
        checks++;
        if (bus.display_value !== 32'h15 || bus.fifo_count !== 3'd0 || bus.overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_end: got %h count=%0d ovf=%b expected %h 0 1", bus.display_value, bus.fifo_count, bus.overflow, 32'h15);
        end
        bus.clr_ovf = 1'b1;
        stepCycle();
        bus.clr_ovf = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_final_clear: got %b expected 0", bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            setCapture(1'b1, 5'd5, 32'h30 + 32'(k));
            stepCycle();
        end
        setCapture(1'b0, 5'd0, 32'h0);
        stepCycle();
        checks++;
        if (bus.fifo_count !== 3'd3 || dut.r_state !== SHOW) begin
            failures++;
            $display("[TB] FAIL midrst_setup: got count=%0d state=%0d expected 3 %0d", bus.fifo_count, dut.r_state, SHOW);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.display_value !== 32'h0 || bus.new_value !== 1'b0 || bus.shown_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs: got %h new=%b shown=%b expected 0 0 0", bus.display_value, bus.new_value, bus.shown_valid);
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0 || dut.r_state !== IDLE) begin
            failures++;
            $display("[TB] FAIL midrst_state: got count=%0d ovf=%b state=%0d expected 0 0 %0d", bus.fifo_count, bus.overflow, dut.r_state, IDLE);
        end
        stepCycle();
        stepCycle();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checks++;
            if (bus.new_value !== 1'b0 || bus.fifo_count !== 3'd0 || bus.display_value !== 32'h0) begin
                failures++;
                $display("[TB] FAIL midrst_after k=%0d: got new=%b count=%0d val=%h expected 0 0 0", k, bus.new_value, bus.fifo_count, bus.display_value);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_filter();
        test_burst();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
